// File: rtl/note_sequencer_ctrl.sv
// Song ROM playback controller: rewinds the selected memory, fetches notes one at a time and holds each for a programmed duration plus a gap.
// Define NOTE_SEQ_LOOP_EN to replay the selected song until stop instead of returning to idle at the end.
module note_sequencer_ctrl #(
    parameter int DATA_WIDTH  = 10,
    parameter int SONG_SEL_W  = 2,
    parameter int NOTE_CYCLES = 50_000_000,
    parameter int GAP_CYCLES  = 5_000_000,
    parameter int CNT_W       = 26
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  pause,
    input  logic [SONG_SEL_W-1:0] song_sel,
    output logic [SONG_SEL_W-1:0] mem_sel,
    output logic                  mem_read_en,
    output logic                  mem_read_rst,
    input  logic [DATA_WIDTH-1:0] mem_data,
    input  logic                  mem_output_ready,
    output logic [DATA_WIDTH-1:0] note_out,
    output logic                  note_valid,
    output logic                  playing,
    output logic                  paused,
    output logic                  song_done,
    output logic [5:0]            note_index
);

    typedef enum logic [2:0] {IDLE, REWIND, FETCH, WAIT, PLAY, GAP, DONE} state_t;

    localparam logic [CNT_W-1:0] NOTE_LOAD = CNT_W'(NOTE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t           state;
    logic [CNT_W-1:0] counter;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            counter      <= '0;
            mem_sel      <= '0;
            mem_read_en  <= 1'b0;
            mem_read_rst <= 1'b0;
            note_out     <= '0;
            note_valid   <= 1'b0;
            playing      <= 1'b0;
            paused       <= 1'b0;
            song_done    <= 1'b0;
            note_index   <= '0;
        end else begin
            mem_read_en  <= 1'b0;
            mem_read_rst <= 1'b0;
            song_done    <= 1'b0;
            if (stop && state != IDLE) begin
                state        <= IDLE;
                counter      <= '0;
                note_out     <= '0;
                note_valid   <= 1'b0;
                paused       <= 1'b0;
                playing      <= 1'b0;
                mem_read_rst <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !stop) begin
                            mem_sel      <= song_sel;
                            mem_read_rst <= 1'b1;
                            note_index   <= '0;
                            playing      <= 1'b1;
                            state        <= REWIND;
                        end
                    end
                    REWIND: state <= FETCH;
                    FETCH: begin
                        mem_read_en <= 1'b1;
                        state       <= WAIT;
                    end
                    WAIT: begin
                        // The strobe is still registered high on the first WAIT cycle;
                        // the memory answers on that edge, so sample one cycle later.
                        if (!mem_read_en) begin
                            if (mem_output_ready) begin
                                note_out   <= mem_data;
                                note_valid <= |mem_data;
                                counter    <= NOTE_LOAD;
                                if (note_index != 6'd63)
                                    note_index <= note_index + 6'd1;
                                state      <= PLAY;
                            end else begin
                                state <= DONE;
                            end
                        end
                    end
                    PLAY: begin
                        if (pause) begin
                            paused     <= 1'b1;
                            note_valid <= 1'b0;
                        end else begin
                            paused <= 1'b0;
                            if (counter == '0) begin
                                note_valid <= 1'b0;
                                if (GAP_CYCLES > 0) begin
                                    counter <= GAP_LOAD;
                                    state   <= GAP;
                                end else begin
                                    state <= FETCH;
                                end
                            end else begin
                                counter    <= counter - CNT_W'(1);
                                note_valid <= |note_out;
                            end
                        end
                    end
                    GAP: begin
                        if (pause) begin
                            paused <= 1'b1;
                        end else begin
                            paused <= 1'b0;
                            if (counter == '0)
                                state <= FETCH;
                            else
                                counter <= counter - CNT_W'(1);
                        end
                    end
                    DONE: begin
                        song_done  <= 1'b1;
                        note_out   <= '0;
                        note_valid <= 1'b0;
`ifdef NOTE_SEQ_LOOP_EN
                        mem_read_rst <= 1'b1;
                        note_index   <= '0;
                        state        <= REWIND;
`else
                        playing <= 1'b0;
                        state   <= IDLE;
`endif
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_note_sequencer_ctrl.sv
// Directed bench for note_sequencer_ctrl with a 3-word song memory model (4-cycle notes, 1-cycle gap).
module tb_note_sequencer_ctrl;
    localparam int DW = 10;
    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0, start = 1'b0, stop = 1'b0, pause = 1'b0;
    logic [SW-1:0] song_sel = '0;
    logic [SW-1:0] mem_sel;
    logic          mem_read_en, mem_read_rst, mem_output_ready;
    logic [DW-1:0] mem_data, note_out;
    logic          note_valid, playing, paused, song_done;
    logic [5:0]    note_index;

    int total = 0, bad = 0, cyc = 0, both_hi = 0;
    int vld, dn, ren, rp, pz, ptr;
    logic [DW-1:0] rom [0:2];

    always #5 clk = ~clk;

    note_sequencer_ctrl #(
        .DATA_WIDTH(DW), .SONG_SEL_W(SW), .NOTE_CYCLES(4), .GAP_CYCLES(1), .CNT_W(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pause(pause),
        .song_sel(song_sel), .mem_sel(mem_sel), .mem_read_en(mem_read_en),
        .mem_read_rst(mem_read_rst), .mem_data(mem_data), .mem_output_ready(mem_output_ready),
        .note_out(note_out), .note_valid(note_valid), .playing(playing), .paused(paused),
        .song_done(song_done), .note_index(note_index)
    );

    // Song memory: rewind on read_rst, data/ready update on the read_en edge.
    always @(posedge clk) begin
        if (!rst_n || mem_read_rst) begin
            ptr = 0;
            mem_output_ready <= 1'b0;
            if (!rst_n) mem_data <= '0;
        end else if (mem_read_en) begin
            if (ptr < 3) begin
                mem_data         <= rom[ptr];
                mem_output_ready <= 1'b1;
                ptr = ptr + 1;
            end else begin
                mem_output_ready <= 1'b0;
            end
        end
        if (mem_read_en && mem_read_rst) both_hi++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic start_song(input logic [SW-1:0] sel);
        song_sel = sel;
        start    = 1'b1;
        step();
        start    = 1'b0;
        cyc      = 1;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (playing && n < 80) begin
            step();
            n++;
        end
        chk(tag, 32'(playing), 0);
    endtask

    initial begin
        rom[0] = 10'h004; rom[1] = 10'h040; rom[2] = 10'h080;
        repeat (3) step();
        chk("rst_note_out", 32'(note_out), 0);
        chk("rst_flags", 32'({note_valid, playing, paused, song_done, mem_read_en, mem_read_rst}), 0);
        chk("rst_sel_idx", 32'({mem_sel, note_index}), 0);
        rst_n = 1'b1;
        step();

        // stop together with start in idle: stop wins
        stop = 1'b1; start = 1'b1;
        step();
        stop = 1'b0; start = 1'b0;
        chk("idle_stop_start", 32'({playing, mem_read_rst}), 0);

        // nominal play
        start_song(2'd1);
        vld = 0; dn = 0; ren = 0;
        chk("nom_rst_pulse", 32'(mem_read_rst), 1);
        chk("nom_mem_sel", 32'(mem_sel), 1);
        chk("nom_playing", 32'(playing), 1);
        while (cyc < 34) begin
            step();
            vld += int'(note_valid); dn += int'(song_done); ren += int'(mem_read_en);
            case (cyc)
                2:  chk("nom_rst_clr", 32'(mem_read_rst), 0);
                3:  chk("nom_fetch", 32'(mem_read_en), 1);
                4:  chk("nom_fetch_once", 32'(mem_read_en), 0);
                5:  chk("nom_note0", 32'({note_valid, note_index, note_out}), {1'b1, 6'd1, 10'h004});
                8:  chk("nom_note0_last", 32'(note_valid), 1);
                9:  chk("nom_gap", 32'({note_valid, note_out}), {1'b0, 10'h004});
                13: chk("nom_note1", 32'({note_valid, note_index, note_out}), {1'b1, 6'd2, 10'h040});
                21: chk("nom_note2", 32'({note_valid, note_index, note_out}), {1'b1, 6'd3, 10'h080});
`ifdef NOTE_SEQ_LOOP_EN
                30: chk("loop_restart", 32'({song_done, mem_read_rst, playing, note_index}), {3'b111, 6'd0});
                32: chk("loop_fetch", 32'(mem_read_en), 1);
                34: chk("loop_note0", 32'({note_valid, note_out}), {1'b1, 10'h004});
`else
                30: chk("nom_done", 32'({song_done, playing, note_out}), {2'b10, 10'h000});
`endif
                default: ;
            endcase
        end
`ifdef NOTE_SEQ_LOOP_EN
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("loop_stop", 32'({playing, song_done, mem_read_rst}), 3'b001);
`else
        chk("nom_valid_cycles", vld, 12);
        chk("nom_done_pulses", dn, 1);
        chk("nom_fetches", ren, 4);
        chk("nom_final", 32'({playing, note_index}), {1'b0, 6'd3});
`endif

        // rest word in the middle
        rom[1] = 10'h000; rom[2] = 10'h008;
        start_song(2'd0);
        vld = 0;
        while (cyc < 22) begin
            step();
            if (cyc >= 13 && cyc <= 16) vld += int'(note_valid);
            if (cyc == 14) chk("rest_idx", 32'({note_index, note_out}), {6'd2, 10'h000});
            if (cyc == 21) chk("rest_next", 32'({note_valid, note_index, note_out}), {1'b1, 6'd3, 10'h008});
        end
        chk("rest_silent", vld, 0);
        stop = 1'b1; step(); stop = 1'b0; step();

        // pause from the 2nd PLAY cycle for 10 cycles
        rom[1] = 10'h040; rom[2] = 10'h080;
        start_song(2'd0);
        vld = 0; pz = 0;
        while (cyc < 20) begin
            step();
            if (cyc == 6) pause = 1'b1;
            if (cyc >= 7 && cyc <= 16) begin
                vld += int'(note_valid);
                pz  += int'(paused);
            end
            if (cyc == 16) pause = 1'b0;
            if (cyc == 17) begin
                chk("pause_resume", 32'({note_valid, paused}), 2'b10);
                vld = 0;
            end
            if (cyc >= 18) vld += int'(note_valid);
            if (cyc == 16) begin
                chk("pause_silent", vld, 0);
                chk("pause_flag", pz, 10);
            end
        end
        chk("pause_tail", vld, 1);
        wait_idle("pause_song_end");

        // stop mid-song, then restart on song 2
        start_song(2'd1);
        while (cyc < 14) step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("stop_outputs", 32'({note_valid, note_out, playing, paused}), 0);
        chk("stop_rewind", 32'({mem_read_rst, song_done}), 2'b10);
        dn = 0;
        repeat (5) begin
            step();
            dn += int'(song_done);
        end
        chk("stop_no_done", dn, 0);
        start_song(2'd2);
        chk("restart_sel", 32'({mem_sel, note_index}), {2'd2, 6'd0});
        while (cyc < 5) step();
        chk("restart_note0", 32'({note_valid, note_index, note_out}), {1'b1, 6'd1, 10'h004});

        // start/song_sel while playing are ignored; reset mid-PLAY
        stop = 1'b1; step(); stop = 1'b0; step();
        start_song(2'd1);
        rp = 0;
        while (cyc < 6) begin
            step();
            rp += int'(mem_read_rst);
            if (cyc == 2) begin start = 1'b1; song_sel = 2'd3; end
            if (cyc == 3) begin start = 1'b0; song_sel = 2'd0; end
            if (cyc == 5) chk("ign_start", 32'({mem_sel, note_index, note_out}), {2'd1, 6'd1, 10'h004});
        end
        chk("ign_no_rewind", rp, 0);
        rst_n = 1'b0;
        step();
        chk("rst_mid_note", 32'({note_out, note_index, mem_sel}), 0);
        chk("rst_mid_flags", 32'({note_valid, playing, paused, song_done, mem_read_en, mem_read_rst}), 0);
        rst_n = 1'b1;
        step();

        chk("rd_exclusive", both_hi, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
